// File: rtl/i2s_tx_if.sv
// PCM sample stream into the I2S transmitter.
// A sample transfers on a rising clock edge where audio_valid_in and
// audio_ready_out are both high; the source must hold audio_in stable until then.
interface i2s_tx_if;
  logic [15:0] audio_in;
  logic        audio_valid_in;
  logic        audio_ready_out;

  modport master (
    output audio_in,
    output audio_valid_in,
    input  audio_ready_out
  );

  modport slave (
    input  audio_in,
    input  audio_valid_in,
    output audio_ready_out
  );
endinterface

// File: rtl/i2s_tx.sv
// I2S transmitter: 64-bit-clock frame, 16-bit mono sample sent MSB-first
// one bit clock after each word-select edge, repeated in left and right slots.
module i2s_tx #(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic     clk_in,
  input  logic     rst_in,
  i2s_tx_if.slave  audio,
  output logic     i2s_clk_out,
  output logic     lrcl_clk_out,
  output logic     dac_data_out,
  output logic     underrun_out
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0]  div_cnt;
  logic [5:0]  bit_cnt;
  logic        buf_full;
  logic [15:0] buf_data;
  logic [15:0] cur_sample;

  logic        div_wrap;
  logic        fall;
  logic        accept;
  logic [5:0]  next_bit;
  logic [4:0]  pos;
  logic [3:0]  sel;
  logic        slot_data;

  assign div_wrap = (div_cnt == DIV_LAST);
  assign fall     = div_wrap && i2s_clk_out;
  assign accept   = audio.audio_valid_in && !buf_full;

  // Slot position after the coming falling edge; bit slots 1..16 carry the sample.
  assign next_bit  = bit_cnt + 6'd1;
  assign pos       = next_bit[4:0];
  assign sel       = 4'(5'd16 - pos);
  assign slot_data = (pos >= 5'd1 && pos <= 5'd16) ? cur_sample[sel] : 1'b0;

  assign audio.audio_ready_out = ~buf_full;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      div_cnt      <= '0;
      bit_cnt      <= '0;
      buf_full     <= 1'b0;
      buf_data     <= '0;
      cur_sample   <= '0;
      i2s_clk_out  <= 1'b0;
      lrcl_clk_out <= 1'b0;
      dac_data_out <= 1'b0;
      underrun_out <= 1'b0;
    end else begin
      underrun_out <= 1'b0;

      if (accept) begin
        buf_data <= audio.audio_in;
        buf_full <= 1'b1;
      end

      if (div_wrap) begin
        div_cnt     <= '0;
        i2s_clk_out <= ~i2s_clk_out;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end

      if (fall) begin
        bit_cnt      <= next_bit;
        lrcl_clk_out <= next_bit[5];
        // Frame load samples the buffer as it stood before this edge, so a
        // same-cycle accept waits for the next frame.
        if (next_bit == 6'd1) begin
          if (buf_full) begin
            cur_sample   <= buf_data;
            buf_full     <= 1'b0;
            dac_data_out <= buf_data[15];
          end else begin
            dac_data_out <= cur_sample[15];
            underrun_out <= 1'b1;
          end
        end else begin
          dac_data_out <= slot_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: cycle model of the handshake and frame timing, with a
// queue of expected frame samples checked against the serial words heard.
module tb_i2s_tx;
  localparam int D     = 2;
  localparam int FRAME = 128 * D;
  localparam int BOUND = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i2s_clk, lrcl_clk, dac_data, underrun;

  i2s_tx_if aud();

  i2s_tx #(.CLK_DIV(D)) dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .audio        (aud),
    .i2s_clk_out  (i2s_clk),
    .lrcl_clk_out (lrcl_clk),
    .dac_data_out (dac_data),
    .underrun_out (underrun)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] acc_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] heard_q[$];

  int          m_cyc = 0;
  int          m_b = 0;
  logic [15:0] m_cur = '0;
  logic        uf_pend = 1'b0;
  int          acc_cnt = 0;
  int          uf_seen = 0;
  logic [15:0] word_acc = '0;
  logic [31:0] rx_sr = '0;
  logic [31:0] rx_word = '0;
  logic        rx_prev_lr = 1'b0;

  // Model advances at each negedge: first check outputs after the last edge,
  // then predict what the next rising edge of clk does.
  always @(negedge clk) begin
    int p;
    int n;
    bit full_before;
    logic exp_bclk;
    logic exp_lr;
    if (rst) begin
      vectors++;
      if ({i2s_clk, lrcl_clk, dac_data, underrun} !== 4'b0000 || aud.audio_ready_out !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_hold: outs=%b ready=%b, required 0000 ready=1",
                 {i2s_clk, lrcl_clk, dac_data, underrun}, aud.audio_ready_out);
      end
      m_cyc = 0; m_b = 0; m_cur = '0; uf_pend = 1'b0;
      acc_q.delete(); exp_q.delete();
      word_acc = '0; rx_sr = '0; rx_prev_lr = 1'b0;
    end else begin
      if (m_cyc > 0) begin
        exp_bclk = ((m_cyc / D) % 2) == 1;
        exp_lr   = (m_b >= 32);
        vectors++;
        if (i2s_clk !== exp_bclk) begin
          miscompares++;
          $display("FAIL bclk cyc=%0d: got %b, required %b", m_cyc, i2s_clk, exp_bclk);
        end
        vectors++;
        if (lrcl_clk !== exp_lr) begin
          miscompares++;
          $display("FAIL lrcl cyc=%0d b=%0d: got %b, required %b", m_cyc, m_b, lrcl_clk, exp_lr);
        end
        vectors++;
        if (underrun !== uf_pend) begin
          miscompares++;
          $display("FAIL underrun cyc=%0d: got %b, required %b", m_cyc, underrun, uf_pend);
        end
        vectors++;
        if (aud.audio_ready_out !== (acc_q.size() == 0)) begin
          miscompares++;
          $display("FAIL ready cyc=%0d: got %b, required %b", m_cyc, aud.audio_ready_out, acc_q.size() == 0);
        end
        if (underrun === 1'b1) uf_seen++;

        if (m_cyc % (2 * D) == D) begin
          p = m_b % 32;
          if (lrcl_clk !== rx_prev_lr) rx_word = rx_sr;
          rx_sr = {rx_sr[30:0], dac_data};
          rx_prev_lr = lrcl_clk;
          if (p >= 1 && p <= 16) begin
            word_acc = {word_acc[14:0], dac_data};
            if (p == 16) begin
              vectors++;
              if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL frame_word b=%0d: got %h, required none pending", m_b, word_acc);
              end else if (word_acc !== exp_q[0]) begin
                miscompares++;
                $display("FAIL frame_word b=%0d: got %h, required %h", m_b, word_acc, exp_q[0]);
              end
              if (m_b < 32) heard_q.push_back(word_acc);
              else if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
          end else begin
            vectors++;
            if (dac_data !== 1'b0) begin
              miscompares++;
              $display("FAIL pad_bit b=%0d: got %b, required 0", m_b, dac_data);
            end
          end
        end
      end

      n = m_cyc + 1;
      uf_pend = 1'b0;
      full_before = (acc_q.size() != 0);
      if (n % (2 * D) == 0) begin
        m_b = (n / (2 * D)) % 64;
        if (m_b == 1) begin
          if (full_before) m_cur = acc_q.pop_front();
          else uf_pend = 1'b1;
          exp_q.push_back(m_cur);
        end
      end
      if (aud.audio_valid_in === 1'b1 && !full_before) begin
        acc_q.push_back(aud.audio_in);
        acc_cnt++;
      end
      m_cyc = n;
    end
  end

  task automatic send(input logic [15:0] s);
    int start;
    int t;
    start = acc_cnt;
    t = 0;
    aud.audio_in = s;
    aud.audio_valid_in = 1'b1;
    while (acc_cnt == start && t < BOUND) begin
      @(posedge clk);
      t++;
    end
    #1;
    aud.audio_valid_in = 1'b0;
    if (t >= BOUND) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: sample %h not accepted in %0d cycles, required accept", s, BOUND);
    end
  endtask

  task automatic wait_bit(input int b);
    int t;
    t = 0;
    while (m_b != b && t < BOUND) begin
      @(posedge clk);
      t++;
    end
    if (t >= BOUND) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_bit_timeout: b=%0d, required %0d", m_b, b);
    end
    #1;
  endtask

  task automatic wait_play(input logic [15:0] s, input int b);
    int t;
    t = 0;
    while (!(m_cur == s && m_b == b) && t < BOUND) begin
      @(posedge clk);
      t++;
    end
    if (t >= BOUND) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_play_timeout: cur=%h b=%0d, required %h at b=%0d", m_cur, m_b, s, b);
    end
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({i2s_clk, lrcl_clk, dac_data, underrun} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b, required 0000", {i2s_clk, lrcl_clk, dac_data, underrun});
    end
    vectors++;
    if (aud.audio_ready_out !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b, required 1", aud.audio_ready_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int uf0;
    uf0 = uf_seen;
    heard_q.delete();
    send(16'hA5C3);
    wait_play(16'hA5C3, 49);
    vectors++;
    if (heard_q.size() != 1 || heard_q[0] !== 16'hA5C3) begin
      miscompares++;
      $display("FAIL basic_word: got %0d words first=%h, required 1 word a5c3",
               heard_q.size(), heard_q.size() > 0 ? heard_q[0] : 16'h0);
    end
    vectors++;
    if (uf_seen != uf0) begin
      miscompares++;
      $display("FAIL basic_underrun: got %0d pulses, required 0", uf_seen - uf0);
    end
  endtask

  task automatic test_back_to_back;
    int uf0;
    logic [15:0] exp [3];
    exp[0] = 16'h0001; exp[1] = 16'h8000; exp[2] = 16'h7FFF;
    uf0 = uf_seen;
    heard_q.delete();
    for (int i = 0; i < 3; i++) send(exp[i]);
    wait_play(16'h7FFF, 49);
    vectors++;
    if (heard_q.size() != 3) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d frames, required 3", heard_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (heard_q[i] !== exp[i]) begin
          miscompares++;
          $display("FAIL b2b_order[%0d]: got %h, required %h", i, heard_q[i], exp[i]);
        end
      end
    end
    vectors++;
    if (uf_seen != uf0) begin
      miscompares++;
      $display("FAIL b2b_underrun: got %0d pulses, required 0", uf_seen - uf0);
    end
  endtask

  task automatic test_starvation;
    int uf0;
    uf0 = uf_seen;
    heard_q.delete();
    send(16'h1234);
    wait_play(16'h1234, 49);
    wait_bit(2);
    wait_bit(49);
    send(16'h5678);
    wait_play(16'h5678, 49);
    vectors++;
    if (heard_q.size() != 3 || heard_q[0] !== 16'h1234 || heard_q[1] !== 16'h1234 || heard_q[2] !== 16'h5678) begin
      miscompares++;
      $display("FAIL starve_seq: got %0d frames last=%h, required 1234 1234 5678",
               heard_q.size(), heard_q.size() > 0 ? heard_q[heard_q.size() - 1] : 16'h0);
    end
    vectors++;
    if (uf_seen - uf0 != 1) begin
      miscompares++;
      $display("FAIL starve_underrun: got %0d pulses, required 1", uf_seen - uf0);
    end
  endtask

  task automatic test_same_cycle;
    int uf0;
    int t;
    uf0 = uf_seen;
    heard_q.delete();
    t = 0;
    while (m_cyc % FRAME != 2 * D - 1 && t < BOUND) begin
      @(posedge clk);
      t++;
    end
    #1;
    send(16'hBEEF);
    wait_play(16'hBEEF, 49);
    vectors++;
    if (heard_q.size() != 2 || heard_q[0] !== 16'h5678 || heard_q[1] !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL same_cycle_seq: got %0d frames first=%h, required 5678 beef",
               heard_q.size(), heard_q.size() > 0 ? heard_q[0] : 16'h0);
    end
    vectors++;
    if (uf_seen - uf0 != 1) begin
      miscompares++;
      $display("FAIL same_cycle_underrun: got %0d pulses, required 1", uf_seen - uf0);
    end
  endtask

  task automatic test_reset_mid_frame;
    int uf0;
    wait_bit(2);
    send(16'h1111);
    wait_bit(40);
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if ({i2s_clk, lrcl_clk, dac_data, underrun} !== 4'b0000) begin
      miscompares++;
      $display("FAIL midreset_outputs: got %b, required 0000", {i2s_clk, lrcl_clk, dac_data, underrun});
    end
    vectors++;
    if (aud.audio_ready_out !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_ready: got %b, required 1", aud.audio_ready_out);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    uf0 = uf_seen;
    heard_q.delete();
    send(16'h00FF);
    wait_play(16'h00FF, 49);
    vectors++;
    if (heard_q.size() != 1 || heard_q[0] !== 16'h00FF) begin
      miscompares++;
      $display("FAIL midreset_word: got %0d words first=%h, required 1 word 00ff",
               heard_q.size(), heard_q.size() > 0 ? heard_q[0] : 16'h0);
    end
    vectors++;
    if (uf_seen != uf0) begin
      miscompares++;
      $display("FAIL midreset_underrun: got %0d pulses, required 0", uf_seen - uf0);
    end
  endtask

  task automatic test_loopback;
    logic [15:0] got;
    send(16'h4321);
    wait_play(16'h4321, 33);
    got = rx_word[30:15];
    vectors++;
    if (got !== 16'h4321) begin
      miscompares++;
      $display("FAIL loopback_rx: got %h (word %h), required 4321", got, rx_word);
    end
  endtask

  initial begin
    aud.audio_in = '0;
    aud.audio_valid_in = 1'b0;
    test_reset;
    test_basic;
    test_back_to_back;
    test_starvation;
    test_same_cycle;
    test_reset_mid_frame;
    test_loopback;
    repeat (10) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/i2s_tx.md
# i2s_tx

I2S transmitter for the playback path: accepts 16-bit mono PCM samples over a valid/ready handshake, generates its own bit clock and word-select clock from the system clock, and serializes each sample MSB-first onto the DAC data line in both the left and right slots. It is the output-side counterpart to the microphone I2S receiver. It uses the same 64-bit-clock frame, with 32 bit-clocks per slot and the sample justified directly after the one-bit I2S delay, so the receiver can capture its output in loopback.

## Interface

- CLK_DIV, 16, clk_in cycles per half bit-clock period; bit-clock period is 2*CLK_DIV; legal range 2..255
- clk_in  input  1  system clock; all logic runs on its rising edge
- rst_in  input  1  reset, asynchronous, active-high
- audio_in  input  16  signed PCM sample
- audio_valid_in  input  1  audio_in holds a sample
- audio_ready_out  output  1  holding buffer empty; = ~buf_full (combinational from the register)
- i2s_clk_out  output  1  bit clock to DAC
- lrcl_clk_out  output  1  word select; 0 = left slot, 1 = right slot
- dac_data_out  output  1  serial data; changes only on i2s_clk_out falling edges
- underrun_out  output  1  one-clk_in pulse when a frame starts with no new sample

## Operation

- State:
  - div_cnt [7:0]
  - bit_cnt [5:0], the current bit slot 0..63
  - buf_full and buf_data [15:0], a one-entry holding buffer
  - cur_sample [15:0], the sample being shifted out
- Accept: when audio_valid_in && audio_ready_out && !rst_in, buf_data <= audio_in and buf_full <= 1.
  - An offer while full is not accepted. The source holds the sample.
- Bit clock:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - i2s_clk_out toggles on each wrap.
  - A wrap while i2s_clk_out==1 is a falling event.
- On each falling event: bit_cnt <= bit_cnt+1, wrapping 63 -> 0.
- Registered outputs for the new slot value b:
  - lrcl_clk_out <= b[5].
  - Let p = b[4:0]. dac_data_out <= (1 <= p <= 16) ? sample[16-p] : 0.
  - The left slot is b = 0..31 and the right slot is b = 32..63. The right slot repeats the same sample.
- Frame load, on the falling event that enters b==1:
  - If buf_full: cur_sample <= buf_data, buf_full <= 0, and dac_data_out takes buf_data[15] on the same edge.
  - If empty: cur_sample is unchanged (the previous sample repeats), dac_data_out takes cur_sample[15], and underrun_out pulses on that clk_in cycle.
- Simultaneous accept and load: the load reads the buffer state before the edge.
  - A sample accepted in the same cycle as a load on an empty buffer stays in the buffer for the next frame, and the underrun still pulses.
  - If the buffer is full, ready is 0, so a simultaneous accept cannot occur.
- Reset (async, rst_in high), all registers clear:
  - i2s_clk_out = lrcl_clk_out = dac_data_out = underrun_out = 0.
  - div_cnt = bit_cnt = 0, buf_full = 0, cur_sample = 0.
  - audio_ready_out reads 1 during reset, but accepts are ignored.
  - Reset mid-frame truncates the frame. Output restarts at bit 0, left slot, with no glitch other than an immediate drop to 0.

## Timing

- Bit-clock edges after reset release:
  - The first rising edge occurs CLK_DIV cycles after the first clk_in edge with rst_in low.
  - The first falling edge occurs at 2*CLK_DIV. This is the entry into b=1 and the first frame load.
- Frame = 64 bit clocks = 128*CLK_DIV clk_in cycles. With the default, 98.304 MHz gives a 3.072 MHz bit clock and 48 kHz frames.
- Load latency: a sample accepted at least one clk_in cycle before the b=1 falling event appears as its MSB on dac_data_out in the cycle after that event. The MSB sits one bit clock after the lrcl_clk_out falling edge (I2S delay).
- lrcl_clk_out and dac_data_out change only coincident with i2s_clk_out falling, so they are stable on every rising edge for the receiver.
- Throughput: at most one sample per frame, so audio_ready_out reasserts once per frame at the b=1 load.
- underrun_out is high for exactly one clk_in cycle per starved frame.

## Test plan

- Reset, then offer 0xA5C3 immediately, CLK_DIV=2:
  - Bit clock period is 4 clk_in cycles.
  - Left slot shifts 1010_0101_1100_0011 in bits 1..16, then zeros in bits 17..31.
  - Right slot repeats the same pattern at bits 33..48.
  - lrcl_clk_out toggles every 32 bit clocks.
  - No underrun.
- Back-to-back stream 0x0001, 0x8000, 0x7FFF with source always valid:
  - One accept per frame; ready drops after each accept and reasserts at each b=1 load.
  - Frames carry the samples in order.
- Starvation: send 0x1234, then withhold the next sample:
  - Second frame repeats 0x1234.
  - underrun_out pulses exactly once, at the b=1 edge.
  - Source resumes with 0x5678 and it plays the following frame.
- Accept in the same cycle as a b=1 load on an empty buffer (0xBEEF):
  - Underrun pulses and the old sample repeats.
  - 0xBEEF plays the next frame.
- Assert rst_in at bit 40 of a frame:
  - All outputs go to 0 asynchronously and ready reads 1.
  - After release, a new 0x00FF plays from a fresh left slot at 2*CLK_DIV.
- Loopback into the microphone I2S receiver with 0x4321:
  - The receiver's captured word bits [30:15] equal 0x4321.
